// File: rtl/alu_nibble_sequencer_if.sv
// Command, ALU-slice and response bundle between the nibble sequencer and its environment.
// The sequencer itself takes the slave view; the environment takes the master view.
interface alu_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [W-1:0]   cmd_a;
  logic [W-1:0]   cmd_b;
  logic [1:0]     cmd_opcode;
  logic           cmd_cin;

  logic [3:0]     alu_a;
  logic [3:0]     alu_b;
  logic [1:0]     alu_opcode;
  logic           alu_cin;
  logic [3:0]     alu_result;
  logic           alu_cout;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_result;
  logic           rsp_cout;
  logic           rsp_zero;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_cin,
    input  cmd_ready,
    input  alu_a, alu_b, alu_opcode, alu_cin,
    output alu_result, alu_cout,
    input  rsp_valid, rsp_result, rsp_cout, rsp_zero,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_cin,
    output cmd_ready,
    output alu_a, alu_b, alu_opcode, alu_cin,
    input  alu_result, alu_cout,
    output rsp_valid, rsp_result, rsp_cout, rsp_zero,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Issue stage for the 4-bit ALU: takes one wide command, walks the operands through the
// ALU one nibble per cycle (LSB first, carry/borrow chained), then returns the wide result.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_nibble_sequencer_if.slave bus
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t           state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     res_q;
  logic [1:0]       op_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;

  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic             rsp_cout_q;
  logic             rsp_zero_q;
  logic [3:0]       alu_a_q;
  logic [3:0]       alu_b_q;
  logic [1:0]       alu_opcode_q;
  logic             alu_cin_q;

  logic             cmd_arith_d;
  logic             cmd_carry_d;
  logic             carry_d;
  logic [W-1:0]     res_d;
  logic [IDX_W-1:0] nxt_idx_d;
  logic [3:0]       nxt_a_d;
  logic [3:0]       nxt_b_d;

  // Next-state helpers: merged result, chained carry and the operand nibbles for the next slice.
  always_comb begin
    cmd_arith_d = ~bus.cmd_opcode[1];
    cmd_carry_d = cmd_arith_d ? bus.cmd_cin : 1'b0;
    carry_d     = (~op_q[1]) ? bus.alu_cout : 1'b0;
    res_d       = res_q;
    nxt_idx_d   = idx_q + 1'b1;
    nxt_a_d     = '0;
    nxt_b_d     = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        res_d[4*n +: 4] = bus.alu_result;
      end
      if (nxt_idx_d == IDX_W'(n)) begin
        nxt_a_d = a_q[4*n +: 4];
        nxt_b_d = b_q[4*n +: 4];
      end
    end
  end

  // Control FSM with registered handshake and ALU-drive outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      op_q         <= '0;
      carry_q      <= 1'b0;
      idx_q        <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_cout_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      alu_cin_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            a_q          <= bus.cmd_a;
            b_q          <= bus.cmd_b;
            op_q         <= bus.cmd_opcode;
            carry_q      <= cmd_carry_d;
            idx_q        <= '0;
            cmd_ready_q  <= 1'b0;
            alu_a_q      <= bus.cmd_a[3:0];
            alu_b_q      <= bus.cmd_b[3:0];
            alu_opcode_q <= bus.cmd_opcode;
            alu_cin_q    <= cmd_carry_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= res_d;
          carry_q <= carry_d;
          if (idx_q == LAST_IDX) begin
            idx_q        <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_cout_q   <= carry_d;
            rsp_zero_q   <= (res_d == '0);
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            alu_cin_q    <= 1'b0;
            state_q      <= DONE;
          end else begin
            idx_q     <= nxt_idx_d;
            alu_a_q   <= nxt_a_d;
            alu_b_q   <= nxt_b_d;
            alu_cin_q <= carry_d;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_cout_q  <= 1'b0;
            rsp_zero_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_cin    = alu_cin_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed scoreboard bench for alu_nibble_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_nibble_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct packed {
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  int         checks = 0;
  int         errors = 0;
  exp_t       expQ[$];
  logic       cinLog[8];
  int         latency;
  logic [4:0] aluSum;

  alu_nibble_sequencer_if #(.NIBBLES(NIBBLES)) bus();

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Behavioural alu_4bit: combinational from the sequencer's alu_* outputs.
  always_comb begin
    aluSum = '0;
    case (bus.alu_opcode)
      2'b00:   aluSum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'b0, bus.alu_cin};
      2'b01:   aluSum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {4'b0, bus.alu_cin};
      2'b10:   aluSum = {1'b0, bus.alu_a & bus.alu_b};
      default: aluSum = {1'b0, bus.alu_a | bus.alu_b};
    endcase
    bus.alu_result = aluSum[3:0];
    bus.alu_cout   = aluSum[4];
  end

  function automatic exp_t expectWide(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [1:0] op, input logic cin);
    logic [W:0] t;
    exp_t e;
    case (op)
      2'b00:   t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      2'b01:   t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      2'b10:   t = {1'b0, a & b};
      default: t = {1'b0, a | b};
    endcase
    e.result = t[W-1:0];
    e.cout   = t[W];
    e.zero   = (t[W-1:0] == '0);
    return e;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkValue({tag, "_cmd_ready"},  32'(bus.cmd_ready),  32'd1);
    checkValue({tag, "_rsp_valid"},  32'(bus.rsp_valid),  32'd0);
    checkValue({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
    checkValue({tag, "_rsp_cout"},   32'(bus.rsp_cout),   32'd0);
    checkValue({tag, "_rsp_zero"},   32'(bus.rsp_zero),   32'd0);
    checkValue({tag, "_alu_a"},      32'(bus.alu_a),      32'd0);
    checkValue({tag, "_alu_b"},      32'(bus.alu_b),      32'd0);
    checkValue({tag, "_alu_opcode"}, 32'(bus.alu_opcode), 32'd0);
    checkValue({tag, "_alu_cin"},    32'(bus.alu_cin),    32'd0);
  endtask

  task automatic driveCmd(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic cin);
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.cmd_opcode = op;
    bus.cmd_cin    = cin;
    bus.cmd_valid  = 1'b1;
  endtask

  // Entered at a falling edge with cmd_valid high; leaves at the falling edge after acceptance.
  task automatic waitAccept(input string tag);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checkValue({tag, "_accept"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Counts edges from acceptance to rsp_valid and logs alu_cin of every EXEC cycle.
  task automatic waitResponse(input string tag);
    latency = 0;
    for (int i = 0; i < 8; i++) cinLog[i] = 1'b0;
    while (bus.rsp_valid !== 1'b1 && latency < 20) begin
      if (latency < 8) cinLog[latency] = bus.alu_cin;
      @(posedge clk);
      @(negedge clk);
      latency++;
    end
    checkValue({tag, "_latency"}, 32'(latency), 32'(NIBBLES));
  endtask

  task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] op, input logic cin);
    expQ.push_back(expectWide(a, b, op, cin));
    driveCmd(a, b, op, cin);
    waitAccept(tag);
    waitResponse(tag);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    checkValue({tag, "_sb_pending"}, 32'(expQ.size() > 0), 32'd1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkValue({tag, "_rsp_valid"},  32'(bus.rsp_valid),  32'd1);
      checkValue({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'(e.result));
      checkValue({tag, "_rsp_cout"},   32'(bus.rsp_cout),   32'(e.cout));
      checkValue({tag, "_rsp_zero"},   32'(bus.rsp_zero),   32'(e.zero));
    end
  endtask

  task automatic completeHandshake(input string tag);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checkValue({tag, "_rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    checkValue({tag, "_idle_ready"},     32'(bus.cmd_ready), 32'd1);
  endtask

  // Directed test sequence.
  initial begin
    logic expCin2[4];
    logic seenValid;
    exp_t held;
    expCin2 = '{1'b0, 1'b1, 1'b1, 1'b1};

    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_a      = '0;
    bus.cmd_b      = '0;
    bus.cmd_opcode = '0;
    bus.cmd_cin    = 1'b0;
    bus.rsp_ready  = 1'b0;

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkValue("post_reset_ready", 32'(bus.cmd_ready), 32'd1);

    $display("[TB] add with internal carries");
    applyStimulus("t1_add", 16'h1234, 16'h0FCD, 2'b00, 1'b0);
    checkOutput("t1_add");
    completeHandshake("t1_add");

    $display("[TB] add wrapping to zero");
    applyStimulus("t2_add", 16'hFFFF, 16'h0001, 2'b00, 1'b0);
    for (int i = 0; i < NIBBLES; i++) begin
      checkValue($sformatf("t2_alu_cin%0d", i), 32'(cinLog[i]), 32'(expCin2[i]));
    end
    checkOutput("t2_add");
    completeHandshake("t2_add");

    $display("[TB] subtract");
    applyStimulus("t3_sub_a", 16'h1000, 16'h0001, 2'b01, 1'b0);
    checkOutput("t3_sub_a");
    completeHandshake("t3_sub_a");
    applyStimulus("t3_sub_b", 16'h0000, 16'h0001, 2'b01, 1'b0);
    checkOutput("t3_sub_b");
    completeHandshake("t3_sub_b");

    $display("[TB] bitwise ops ignore carry-in");
    applyStimulus("t4_and", 16'hA5F0, 16'h0FFF, 2'b10, 1'b1);
    for (int i = 0; i < NIBBLES; i++) begin
      checkValue($sformatf("t4_and_alu_cin%0d", i), 32'(cinLog[i]), 32'd0);
    end
    checkOutput("t4_and");
    completeHandshake("t4_and");
    applyStimulus("t4_or", 16'hA500, 16'h005A, 2'b11, 1'b1);
    for (int i = 0; i < NIBBLES; i++) begin
      checkValue($sformatf("t4_or_alu_cin%0d", i), 32'(cinLog[i]), 32'd0);
    end
    checkOutput("t4_or");
    completeHandshake("t4_or");

    $display("[TB] response backpressure with pending command");
    applyStimulus("t5_first", 16'h0F0F, 16'h0101, 2'b00, 1'b1);
    held = (expQ.size() > 0) ? expQ[0] : '0;
    driveCmd(16'h0003, 16'h0004, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkValue($sformatf("t5_hold%0d_valid", i),  32'(bus.rsp_valid),  32'd1);
      checkValue($sformatf("t5_hold%0d_result", i), 32'(bus.rsp_result), 32'(held.result));
      checkValue($sformatf("t5_hold%0d_cout", i),   32'(bus.rsp_cout),   32'(held.cout));
      checkValue($sformatf("t5_hold%0d_ready", i),  32'(bus.cmd_ready),  32'd0);
    end
    checkOutput("t5_first");
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checkValue("t5_bubble_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkValue("t5_bubble_ready",     32'(bus.cmd_ready), 32'd1);
    expQ.push_back(expectWide(16'h0003, 16'h0004, 2'b00, 1'b0));
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkValue("t5_accepted", 32'(bus.cmd_ready), 32'd0);
    waitResponse("t5_second");
    checkOutput("t5_second");
    completeHandshake("t5_second");

    $display("[TB] reset during execution");
    driveCmd(16'h4321, 16'h1111, 2'b00, 1'b0);
    waitAccept("t6_abort");
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkValue("t6_pre_alu_a", 32'(bus.alu_a), 32'h3);
    #1 rst_n = 1'b0;
    #1 checkResetOutputs("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    seenValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seenValid = 1'b1;
    end
    checkValue("t6_no_response", 32'(seenValid), 32'd0);
    applyStimulus("t6_fresh", 16'h0001, 16'h0001, 2'b00, 1'b0);
    checkOutput("t6_fresh");
    completeHandshake("t6_fresh");

    checkValue("sb_drained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
